sipo_deserializer: RTL and testbench

Parametrised serial-in/parallel-out deserializer, the successor to the fixed 4-bit SIPO shift register. It collects WIDTH serial bits into a word, MSB-first or LSB-first, and tracks bit position with a counter. Completed words go to a one-word output buffer with valid/ready handshake, so shifting continues while a word waits. It sits between a bit-serial source (link receiver, bit-banged peripheral) and word-oriented logic.

---
 rtl/sipo_pkg.sv | 13 +
 rtl/sipo_word_buf.sv | 27 ++
 rtl/sipo_deserializer.sv | 70 +++++++
 tb/tb_sipo_deserializer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/sipo_pkg.sv
// Shared constants and helpers for the serial-in/parallel-out deserializer family.
package sipo_pkg;

  localparam int SIPO_MAX_WIDTH = 64;

  // Counter width for a w-bit word, never narrower than one bit.
  function automatic int cnt_width(input int w);
    int c;
    c = $clog2(w);
    return (c < 1) ? 1 : c;
  endfunction

endpackage

// File: rtl/sipo_word_buf.sv
// One-entry valid/ready word register: load wins over drain, so a load in the drain cycle replaces the word.
// Loaded word is visible the cycle after load; the word is held stable until p_ready drains it.
module sipo_word_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_dat,
  output logic [WIDTH-1:0] p_out,
  output logic             p_valid,
  input  logic             p_ready
);

  always_ff @(posedge clk) begin
    if (rst) begin
      p_out   <= '0;
      p_valid <= 1'b0;
    end else if (load) begin
      p_out   <= load_dat;
      p_valid <= 1'b1;
    end else if (p_valid && p_ready) begin
      p_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/sipo_deserializer.sv
// Collects WIDTH serial bits into a word; completed word is visible the cycle after its last bit.
// Only the final bit of a word is stalled (s_ready=0) while the output buffer is full and not draining.
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CW       = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             s_in,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] p_out,
  output logic             p_valid,
  input  logic             p_ready,
  output logic [CW-1:0]    bit_cnt
);

  if (WIDTH < 2 || WIDTH > SIPO_MAX_WIDTH) begin : g_bad_width
    $error("sipo_deserializer: WIDTH %0d outside 2..%0d", WIDTH, SIPO_MAX_WIDTH);
  end

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] sh_next;
  logic [CW-1:0]    cnt;
  logic             last_bit;
  logic             accept;
  logic             complete;

  if (MSB_FIRST) begin : g_msb
    assign sh_next = {sh[WIDTH-2:0], s_in};
  end else begin : g_lsb
    assign sh_next = {s_in, sh[WIDTH-1:1]};
  end

  assign last_bit = (cnt == LAST);
  // Only the completing bit can overrun the buffer, so only it is held off.
  assign s_ready  = !(last_bit && p_valid && !p_ready);
  assign accept   = s_valid && s_ready && !clr;
  assign complete = accept && last_bit;
  assign bit_cnt  = cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sh  <= '0;
      cnt <= '0;
    end else if (accept) begin
      sh  <= sh_next;
      cnt <= last_bit ? '0 : cnt + 1'b1;
    end
  end

  sipo_word_buf #(
    .WIDTH(WIDTH)
  ) u_word_buf (
    .clk     (clk),
    .rst     (rst),
    .load    (complete),
    .load_dat(sh_next),
    .p_out   (p_out),
    .p_valid (p_valid),
    .p_ready (p_ready)
  );

endmodule

// File: tb/tb_sipo_deserializer.sv
// Self-checking bench: MSB-first and LSB-first instances driven in lockstep, scoreboard on output words.
module tb_sipo_deserializer;

  logic       clk = 1'b0;
  logic       rst, clr, s_in, s_valid, p_ready;
  logic       s_ready, p_valid, s_ready_l, p_valid_l;
  logic [7:0] p_out, p_out_l;
  logic [2:0] bit_cnt, bit_cnt_l;

  always #5 clk = ~clk;

  sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .clr(clr), .s_in(s_in), .s_valid(s_valid), .s_ready(s_ready),
    .p_out(p_out), .p_valid(p_valid), .p_ready(p_ready), .bit_cnt(bit_cnt)
  );

  sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .clr(clr), .s_in(s_in), .s_valid(s_valid), .s_ready(s_ready_l),
    .p_out(p_out_l), .p_valid(p_valid_l), .p_ready(p_ready), .bit_cnt(bit_cnt_l)
  );

  typedef struct {
    logic [7:0] word;
    logic [7:0] exp_msb;
    logic [7:0] exp_lsb;
  } vec_t;

  typedef struct {
    logic [7:0] msb;
    logic [7:0] lsb;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   stalls = 0;
  int   valid_cycles = 0;
  logic prev_valid = 1'b0;
  logic prev_hs = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] m, input logic [7:0] l);
    exp_t e;
    e.msb = m;
    e.lsb = l;
    sb.push_back(e);
  endtask

  // Presents one bit and holds it until accepted (bounded).
  task automatic send_bit(input logic b);
    int w;
    w = 0;
    s_valid = 1'b1;
    s_in    = b;
    @(negedge clk);
    while (!s_ready && w < 50) begin
      w++;
      stalls++;
      @(negedge clk);
    end
    if (!s_ready) check("send_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] w, input int n);
    for (int i = 7; i > 7 - n; i--) send_bit(w[i]);
  endtask

  // A new word appears when p_valid rises or is reloaded in a handshake cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1) begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
      sb.delete();
    end else begin
      if (p_valid === 1'b1) valid_cycles++;
      if (p_valid === 1'b1 && (!prev_valid || prev_hs)) begin
        if (sb.size() == 0) begin
          check("unexpected_word", 64'(p_out), 64'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("word_msb", 64'(p_out), 64'(e.msb));
          check("word_lsb", 64'(p_out_l), 64'(e.lsb));
          check("valid_lsb", 64'(p_valid_l), 64'd1);
        end
      end
      prev_valid = (p_valid === 1'b1);
      prev_hs    = (p_valid === 1'b1) && (p_ready === 1'b1);
    end
  end

  initial begin
    vec_t tbl[5];
    tbl[0] = '{word: 8'hC0, exp_msb: 8'hC0, exp_lsb: 8'h03};
    tbl[1] = '{word: 8'hA5, exp_msb: 8'hA5, exp_lsb: 8'hA5};
    tbl[2] = '{word: 8'h3C, exp_msb: 8'h3C, exp_lsb: 8'h3C};
    tbl[3] = '{word: 8'h01, exp_msb: 8'h01, exp_lsb: 8'h80};
    tbl[4] = '{word: 8'h96, exp_msb: 8'h96, exp_lsb: 8'h69};

    rst = 1'b1; clr = 1'b0; s_in = 1'b0; s_valid = 1'b0; p_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_p_out", 64'(p_out), 64'd0);
    check("rst_p_valid", 64'(p_valid), 64'd0);
    check("rst_bit_cnt", 64'(bit_cnt), 64'd0);
    check("rst_s_ready", 64'(s_ready), 64'd1);
    @(posedge clk);
    #1;

    // Back-to-back words with p_ready tied high: no stalls, one valid cycle per word.
    stalls = 0;
    valid_cycles = 0;
    for (int k = 0; k < 5; k++) begin
      for (int i = 7; i >= 0; i--) begin
        send_bit(tbl[k].word[i]);
        check("stream_bit_cnt", 64'(bit_cnt), 64'((8 - i) % 8));
      end
      push(tbl[k].exp_msb, tbl[k].exp_lsb);
    end
    s_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("stream_stalls", 64'(stalls), 64'd0);
    check("stream_valid_cycles", 64'(valid_cycles), 64'd5);
    check("stream_sb_empty", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;

    // Backpressure: the 8th bit of the second word is held while A5 waits.
    p_ready = 1'b0;
    stalls = 0;
    send_bits(8'hA5, 8);
    push(8'hA5, 8'hA5);
    send_bits(8'h5A, 7);
    check("bp_no_early_stall", 64'(stalls), 64'd0);
    s_valid = 1'b1;
    s_in    = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_s_ready_low", 64'(s_ready), 64'd0);
      check("bp_p_out_held", 64'(p_out), 64'hA5);
      check("bp_p_valid", 64'(p_valid), 64'd1);
      check("bp_bit_cnt", 64'(bit_cnt), 64'd7);
    end
    @(posedge clk);
    #1 p_ready = 1'b1;
    push(8'h5A, 8'h5A);
    @(negedge clk);
    check("bp_s_ready_high", 64'(s_ready), 64'd1);
    @(posedge clk);
    #1 s_valid = 1'b0;
    @(negedge clk);
    check("bp_p_valid_cont", 64'(p_valid), 64'd1);
    check("bp_p_out_new", 64'(p_out), 64'h5A);
    check("bp_bit_cnt_wrap", 64'(bit_cnt), 64'd0);
    @(posedge clk);
    #1;

    // Abort with a buffered word pending.
    p_ready = 1'b0;
    send_bits(8'h96, 8);
    push(8'h96, 8'h69);
    send_bits(8'hA8, 5);
    check("clr_pre_bit_cnt", 64'(bit_cnt), 64'd5);
    clr = 1'b1;
    s_valid = 1'b1;
    s_in = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    check("clr_bit_cnt", 64'(bit_cnt), 64'd0);
    check("clr_p_out_kept", 64'(p_out), 64'h96);
    check("clr_p_valid_kept", 64'(p_valid), 64'd1);
    @(posedge clk);
    #1 p_ready = 1'b1;
    send_bits(8'hFF, 8);
    push(8'hFF, 8'hFF);
    s_valid = 1'b0;
    @(negedge clk);
    check("clr_p_out_ff", 64'(p_out), 64'hFF);
    @(posedge clk);
    #1;

    // Reset mid-operation.
    p_ready = 1'b0;
    send_bits(8'hA5, 8);
    push(8'hA5, 8'hA5);
    send_bits(8'hE0, 3);
    s_valid = 1'b0;
    @(negedge clk);
    check("mid_p_valid", 64'(p_valid), 64'd1);
    check("mid_bit_cnt", 64'(bit_cnt), 64'd3);
    check("mid_sb_empty", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mrst_p_valid", 64'(p_valid), 64'd0);
    check("mrst_p_out", 64'(p_out), 64'd0);
    check("mrst_p_out_lsb", 64'(p_out_l), 64'd0);
    check("mrst_bit_cnt", 64'(bit_cnt), 64'd0);
    check("mrst_s_ready", 64'(s_ready), 64'd1);

    repeat (2) @(negedge clk);
    check("final_sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
